// File: rtl/pipeline_run_controller_pkg.sv
// Run-mode codes and one-hot state encoding for the debug run controller.
// Shared with the UART debug unit so both sides agree on the mode encoding.
package pipeline_run_controller_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_CONT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b11;

  localparam logic [5:0] ST_IDLE      = 6'b000001;
  localparam logic [5:0] ST_RUN_CONT  = 6'b000010;
  localparam logic [5:0] ST_STEP_WAIT = 6'b000100;
  localparam logic [5:0] ST_STEP_EXEC = 6'b001000;
  localparam logic [5:0] ST_STEP_DUMP = 6'b010000;
  localparam logic [5:0] ST_DONE      = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE      = ST_IDLE,
    S_RUN_CONT  = ST_RUN_CONT,
    S_STEP_WAIT = ST_STEP_WAIT,
    S_STEP_EXEC = ST_STEP_EXEC,
    S_STEP_DUMP = ST_STEP_DUMP,
    S_DONE      = ST_DONE
  } state_t;

endpackage

// File: rtl/pipeline_run_controller_saturating_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Clear wins over enable; value is registered (one-cycle update latency).
module saturating_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (enable && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_controller.sv
// Gates the pipeline global enable for continuous or single-step debug runs,
// detects HALT retirement / cycle-limit timeout and requests a dump after each step.
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int CYCLE_COUNT_WIDTH = 32,
  parameter int MAX_CYCLES        = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [1:0]                   i_start_pipeline,
  input  logic                         i_step_request,
  input  logic                         i_halt_in_wb,
  input  logic                         i_dump_done,
  output logic                         o_pipeline_enable,
  output logic                         o_dump_request,
  output logic                         o_program_finished,
  output logic                         o_timeout,
  output logic [CYCLE_COUNT_WIDTH-1:0] o_cycle_count,
  output logic                         o_busy
);

  // Compared against the pre-increment count, so the limit cycle itself is counted.
  localparam logic [CYCLE_COUNT_WIDTH-1:0] LAST_CYCLE = CYCLE_COUNT_WIDTH'(MAX_CYCLES - 1);

  state_t state_q, state_d;
  logic   timeout_q, timeout_d;
  logic   halt_q, halt_d;
  logic   count_clear;
  logic   stop_req;

  assign stop_req = (i_start_pipeline == MODE_STOP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      timeout_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    halt_d      = halt_q;
    count_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start_pipeline == MODE_CONT || i_start_pipeline == MODE_STEP) begin
          state_d     = (i_start_pipeline == MODE_CONT) ? S_RUN_CONT : S_STEP_WAIT;
          count_clear = 1'b1;
          halt_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_RUN_CONT: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (i_halt_in_wb) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (o_cycle_count == LAST_CYCLE) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_STEP_WAIT: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (i_step_request) begin
          state_d = S_STEP_EXEC;
        end
      end
      S_STEP_EXEC: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STEP_DUMP;
          halt_d  = i_halt_in_wb;
        end
      end
      S_STEP_DUMP: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (i_dump_done) begin
          state_d = halt_q ? S_DONE : S_STEP_WAIT;
          if (halt_q) timeout_d = 1'b0;
        end
      end
      S_DONE: begin
        if (stop_req) begin
          state_d   = S_IDLE;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_pipeline_enable  = (state_q == S_RUN_CONT) || (state_q == S_STEP_EXEC);
  assign o_dump_request     = (state_q == S_STEP_DUMP);
  assign o_program_finished = (state_q == S_DONE);
  assign o_timeout          = timeout_q;
  assign o_busy             = (state_q != S_IDLE);

  saturating_counter #(
    .WIDTH (CYCLE_COUNT_WIDTH)
  ) u_cycle_counter (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (count_clear),
    .enable (o_pipeline_enable),
    .value  (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench: each step pushes the expected post-edge outputs to a queue,
// which is popped and compared once the DUT has updated after the clock edge.
module tb_pipeline_run_controller;
  import pipeline_run_controller_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic         en;
    logic         dump;
    logic         fin;
    logic         to;
    logic         busy;
    logic [W-1:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = MODE_STOP;
  logic         step = 1'b0;
  logic         halt = 1'b0;
  logic         done = 1'b0;
  logic         en, dump, fin, to, busy;
  logic [W-1:0] cnt;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  pipeline_run_controller #(
    .CYCLE_COUNT_WIDTH (W),
    .MAX_CYCLES        (16)
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_start_pipeline   (mode),
    .i_step_request     (step),
    .i_halt_in_wb       (halt),
    .i_dump_done        (done),
    .o_pipeline_enable  (en),
    .o_dump_request     (dump),
    .o_program_finished (fin),
    .o_timeout          (to),
    .o_cycle_count      (cnt),
    .o_busy             (busy)
  );

  function automatic obs_t mk(input logic e, d, f, t, b, input int c);
    obs_t o;
    o.en = e; o.dump = d; o.fin = f; o.to = t; o.busy = b; o.cnt = W'(c);
    return o;
  endfunction

  task automatic check_head();
    sb_t  e;
    obs_t o;
    e = sb_q.pop_front();
    o = {en, dump, fin, to, busy, cnt};
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: en/dump/fin/to/busy observed %b%b%b%b%b cnt %0d, expected %b%b%b%b%b cnt %0d",
             e.tag, o.en, o.dump, o.fin, o.to, o.busy, o.cnt,
             e.exp.en, e.exp.dump, e.exp.fin, e.exp.to, e.exp.busy, e.exp.cnt);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after that edge.
  task automatic drive(input logic [1:0] m, input logic s, h, d,
                       input string tag, input obs_t exp);
    mode = m; step = s; halt = h; done = d;
    sb_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "reset", mk(0,0,0,0,0,0));
    rst = 1'b0;
    drive(MODE_STOP, 1'b1, 1'b1, 1'b1, "idle_after_reset", mk(0,0,0,0,0,0));
    drive(2'b10, 1'b0, 1'b0, 1'b0, "idle_reserved_mode", mk(0,0,0,0,0,0));

    // Continuous run, HALT on the 11th enabled cycle
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "cont_start", mk(1,0,0,0,1,0));
    for (int i = 1; i <= 10; i++)
      drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "cont_run", mk(1,0,0,0,1,i));
    drive(MODE_CONT, 1'b0, 1'b1, 1'b0, "cont_halt", mk(0,0,1,0,1,11));
    drive(MODE_CONT, 1'b1, 1'b1, 1'b1, "cont_done_hold", mk(0,0,1,0,1,11));
    drive(MODE_STOP, 1'b0, 1'b0, 1'b0, "cont_back_idle", mk(0,0,0,0,0,11));

    // Continuous run to the 16-cycle limit, with ignored mid-run mode changes
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "to_start", mk(1,0,0,0,1,0));
    for (int i = 1; i <= 15; i++)
      drive((i >= 5 && i <= 7) ? MODE_STEP : ((i == 9) ? 2'b10 : MODE_CONT),
            1'b0, 1'b0, 1'b0, "to_run", mk(1,0,0,0,1,i));
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "to_limit", mk(0,0,1,1,1,16));
    drive(2'b10, 1'b0, 1'b1, 1'b0, "to_done_hold", mk(0,0,1,1,1,16));
    drive(MODE_STOP, 1'b0, 1'b0, 1'b0, "to_back_idle", mk(0,0,0,0,0,16));

    // Stepwise: three steps, 6-cycle dumps, dropped pulse during dump
    drive(MODE_STEP, 1'b0, 1'b0, 1'b0, "step_start", mk(0,0,0,0,1,0));
    drive(MODE_STEP, 1'b0, 1'b1, 1'b0, "step_wait_hold", mk(0,0,0,0,1,0));
    for (int s = 0; s < 3; s++) begin
      drive(MODE_STEP, 1'b1, 1'b0, 1'b0, "step_exec", mk(1,0,0,0,1,s));
      drive(MODE_STEP, 1'b0, 1'b0, 1'b0, "step_dump_enter", mk(0,1,0,0,1,s+1));
      for (int j = 0; j < 5; j++)
        drive(MODE_STEP, (j == 2), (j == 1), 1'b0, "step_dump_hold", mk(0,1,0,0,1,s+1));
      drive(MODE_STEP, 1'b0, 1'b0, 1'b1, "step_dump_done", mk(0,0,0,0,1,s+1));
    end
    drive(MODE_STEP, 1'b0, 1'b0, 1'b0, "step_pulse_dropped", mk(0,0,0,0,1,3));

    // Fourth step retires HALT
    drive(MODE_STEP, 1'b1, 1'b0, 1'b0, "halt_step_exec", mk(1,0,0,0,1,3));
    drive(MODE_STEP, 1'b0, 1'b1, 1'b0, "halt_step_dump", mk(0,1,0,0,1,4));
    drive(MODE_STEP, 1'b0, 1'b0, 1'b0, "halt_step_dump_hold", mk(0,1,0,0,1,4));
    drive(MODE_STEP, 1'b0, 1'b0, 1'b1, "halt_step_done", mk(0,0,1,0,1,4));
    drive(MODE_STEP, 1'b1, 1'b0, 1'b0, "halt_step_done_hold", mk(0,0,1,0,1,4));
    drive(MODE_STOP, 1'b0, 1'b0, 1'b0, "halt_step_idle", mk(0,0,0,0,0,4));

    // Abort in STEP_DUMP with a same-cycle step pulse
    drive(MODE_STEP, 1'b0, 1'b0, 1'b0, "abort_start", mk(0,0,0,0,1,0));
    drive(MODE_STEP, 1'b1, 1'b0, 1'b0, "abort_exec", mk(1,0,0,0,1,0));
    drive(MODE_STEP, 1'b0, 1'b1, 1'b0, "abort_dump", mk(0,1,0,0,1,1));
    drive(MODE_STOP, 1'b1, 1'b0, 1'b1, "abort_to_idle", mk(0,0,0,0,0,1));
    for (int i = 0; i < 3; i++)
      drive(MODE_STOP, 1'b0, 1'b0, 1'b0, "abort_no_finish", mk(0,0,0,0,0,1));

    // Synchronous reset in RUN_CONT at count 7
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "rst_run_start", mk(1,0,0,0,1,0));
    for (int i = 1; i <= 7; i++)
      drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "rst_run", mk(1,0,0,0,1,i));
    rst = 1'b1;
    drive(MODE_CONT, 1'b0, 1'b0, 1'b0, "rst_midrun", mk(0,0,0,0,0,0));
    rst = 1'b0;
    drive(MODE_STOP, 1'b0, 1'b0, 1'b0, "rst_idle", mk(0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
